// File: rtl/rose_delay_responder.sv
// Responder for "$rose(signal_0) |-> ##DELAY signal_1": each accepted 0->1 edge on
// signal_0 becomes exactly one signal_1 pulse, seen by a sampler DELAY cycles later.
module rose_delay_responder #(
  parameter int DELAY = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             signal_0,
  output logic             signal_1,
  output logic [4:0]       pending,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] resp_cnt
);

  logic             prev_s0;
  logic [DELAY-1:0] pipe;
  logic             rise;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}}))
      return v + CNT_W'(1);
    return v;
  endfunction

  // prev_s0 clears to 0 so a level already high at the first post-reset edge counts as a rise
  assign rise     = signal_0 & ~prev_s0 & enable;
  assign signal_1 = pipe[DELAY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_s0  <= 1'b0;
      pipe     <= '0;
      pending  <= '0;
      rise_cnt <= '0;
      resp_cnt <= '0;
    end else begin
      prev_s0 <= signal_0;
      pipe[0] <= rise;
      for (int i = 1; i < DELAY; i++)
        pipe[i] <= pipe[i-1];
      // a pulse counts as issued on the edge that samples it high
      pending  <= pending + 5'(rise) - 5'(signal_1);
      rise_cnt <= sat_inc(rise_cnt, rise);
      resp_cnt <= sat_inc(resp_cnt, signal_1);
    end
  end

endmodule

// File: tb/tb_rose_delay_responder.sv
// Randomized scoreboard bench for rose_delay_responder: a cycle-level model queues
// the due time of every accepted rise; a negedge monitor pops and compares.
module tb_rose_delay_responder;
  localparam int DELAY   = 2;
  localparam int CNT_W   = 8;
  localparam int SAT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             signal_0 = 1'b0;
  logic             signal_1;
  logic [4:0]       pending;
  logic [CNT_W-1:0] rise_cnt;
  logic [CNT_W-1:0] resp_cnt;

  rose_delay_responder #(.DELAY(DELAY), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .signal_0 (signal_0),
    .signal_1 (signal_1),
    .pending  (pending),
    .rise_cnt (rise_cnt),
    .resp_cnt (resp_cnt)
  );

  always #2 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   exp_q[$];
  int   inflight[$];
  int   m_rise = 0;
  int   m_resp = 0;
  int   m_pend = 0;
  logic m_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: evaluated on each posedge from the sampled inputs
  always @(posedge clk) begin
    logic r;
    cyc = cyc + 1;
    if (!rst_n) begin
      m_prev = 1'b0;
      exp_q.delete();
      inflight.delete();
      m_rise = 0;
      m_resp = 0;
      m_pend = 0;
    end else begin
      while (inflight.size() > 0 && inflight[0] == cyc) begin
        void'(inflight.pop_front());
        if (m_resp < SAT_MAX) m_resp++;
        m_pend--;
      end
      r = signal_0 && !m_prev && enable;
      m_prev = signal_0;
      if (r) begin
        inflight.push_back(cyc + DELAY);
        exp_q.push_back(cyc + DELAY);
        if (m_rise < SAT_MAX) m_rise++;
        m_pend++;
      end
    end
  end

  // Monitor: outputs settled after posedge cyc are what posedge cyc+1 samples
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_signal_1", int'(signal_1), 0);
        check("reset_pending", int'(pending), 0);
        check("reset_rise_cnt", int'(rise_cnt), 0);
        check("reset_resp_cnt", int'(resp_cnt), 0);
      end else if (cyc > 0) begin
        bit exp_s1;
        exp_s1 = (exp_q.size() > 0) && (exp_q[0] == cyc + 1);
        if (exp_s1) void'(exp_q.pop_front());
        check("signal_1", int'(signal_1), int'(exp_s1));
        check("rise_cnt", int'(rise_cnt), m_rise);
        check("resp_cnt", int'(resp_cnt), m_resp);
        check("pending", int'(pending), m_pend);
        check("pending_bound", int'(pending <= DELAY), 1);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 2600; i++) begin
      @(negedge clk);
      #1;
      if ((i % 400) < 40)
        signal_0 = ~signal_0;
      else if ($urandom_range(0, 2) == 0)
        signal_0 = ~signal_0;
      enable = ($urandom_range(0, 9) != 0);
      if (i == 600) rst_n = 1'b0;
      if (i == 603) rst_n = 1'b1;
    end
    @(negedge clk);
    #1 signal_0 = 1'b0;
    repeat (DELAY + 3) @(negedge clk);
    #1;
    check("drain_queue_empty", exp_q.size(), 0);
    check("rise_saturated", int'(rise_cnt), SAT_MAX);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
